// File: rtl/mo_responder.sv
// mo_responder: responder end of the matrix-operator opcode bus, with host load/readback and opcode sequencing checks
module mo_responder #(
  parameter int MAX_N = 8,
  parameter int DW    = 10,
  parameter int YW    = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic [2:0]    ld_sel,
  input  logic [DW-1:0] ld_i,
  input  logic [DW-1:0] ld_j,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  input  logic [2:0]    opcode,
  input  logic [DW-1:0] i,
  input  logic [DW-1:0] j,
  input  logic [YW-1:0] out_data,
  input  logic          fin,
  output logic [DW-1:0] in_data,
  input  logic [DW-1:0] rd_i,
  input  logic [DW-1:0] rd_j,
  output logic [YW-1:0] y_rdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] y_cnt,
  output logic          err_proto
);
  localparam int AW = $clog2(MAX_N * MAX_N);
  localparam logic [DW-1:0] MN = DW'(MAX_N);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  localparam logic [2:0] OP_GET_N = 3'd0, OP_GET_R = 3'd1, OP_READ_A = 3'd2, OP_READ_X = 3'd3;
  localparam logic [2:0] OP_READ_B = 3'd4, OP_WRITE_Y = 3'd5, OP_INIT = 3'd7;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] n_q, n_d, r_q, r_d, y_cnt_q, y_cnt_d;
  logic [2:0]    prev_op_q, prev_op_d;
  logic          err_q, err_d;
  logic [DW-1:0] a_mem [MAX_N*MAX_N];
  logic [DW-1:0] x_mem [MAX_N*MAX_N];
  logic [DW-1:0] b_mem [MAX_N*MAX_N];
  logic [YW-1:0] y_mem [MAX_N*MAX_N];
  logic          run, idle, start_go, op_ok, legal, ld_go, y_we;
  logic [AW-1:0] op_addr, ld_addr, rd_addr;
  function automatic logic [AW-1:0] addr(input logic [DW-1:0] r, input logic [DW-1:0] c);
    return AW'(int'(r) * MAX_N + int'(c));
  endfunction
  always_comb begin
    run = state_q == S_RUN;
    idle = state_q == S_IDLE;
    start_go = start && !run;
    op_ok = i < MN && j < MN && i < n_q && j < n_q;
    op_addr = addr(i, j);
    ld_addr = addr(ld_i, ld_j);
    rd_addr = addr(rd_i, rd_j);
    ld_go = idle && ld_en && ld_i < MN && ld_j < MN;
    y_we = run && opcode == OP_WRITE_Y && op_ok;
    legal = opcode == OP_INIT
         || (prev_op_q == OP_INIT    && opcode == OP_GET_N)
         || (prev_op_q == OP_GET_N   && opcode == OP_GET_R)
         || (prev_op_q == OP_GET_R   && opcode == OP_READ_A)
         || (prev_op_q == OP_READ_A  && opcode == OP_READ_X)
         || (prev_op_q == OP_READ_X  && (opcode == OP_READ_A || opcode == OP_READ_B))
         || (prev_op_q == OP_READ_B  && opcode == OP_WRITE_Y)
         || (prev_op_q == OP_WRITE_Y && opcode == OP_READ_A);
    in_data = !run                  ? '0 :
              opcode == OP_GET_N    ? n_q :
              opcode == OP_GET_R    ? r_q :
              !op_ok                ? '0 :
              opcode == OP_READ_A   ? a_mem[op_addr] :
              opcode == OP_READ_X   ? x_mem[op_addr] :
              opcode == OP_READ_B   ? b_mem[op_addr] : '0;
    y_rdata = (rd_i < MN && rd_j < MN) ? y_mem[rd_addr] : '0;
    state_d = run ? (fin ? S_DONE : S_RUN) : (start ? S_RUN : state_q);
    n_d = (idle && ld_en && ld_sel == 3'd0) ? ld_data : n_q;
    r_d = (idle && ld_en && ld_sel == 3'd1) ? ld_data : r_q;
    prev_op_d = start_go ? OP_INIT : run ? opcode : prev_op_q;
    y_cnt_d = start_go ? '0 : y_we ? y_cnt_q + DW'(1) : y_cnt_q;
    err_d = start_go ? 1'b0 : (run && !legal) || err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q <= '0;
      r_q <= '0;
      prev_op_q <= OP_INIT;
      y_cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      r_q <= r_d;
      prev_op_q <= prev_op_d;
      y_cnt_q <= y_cnt_d;
      err_q <= err_d;
    end
  end
  // matrix storage has no reset so contents survive it; a reset cycle only blocks new writes
  always_ff @(posedge clk) begin
    if (!reset && ld_go && ld_sel == 3'd2) a_mem[ld_addr] <= ld_data;
    if (!reset && ld_go && ld_sel == 3'd3) x_mem[ld_addr] <= ld_data;
    if (!reset && ld_go && ld_sel == 3'd4) b_mem[ld_addr] <= ld_data;
    if (!reset && y_we) y_mem[op_addr] <= out_data;
  end
  assign busy = run;
  assign done = state_q == S_DONE;
  assign y_cnt = y_cnt_q;
  assign err_proto = err_q;
endmodule

// File: tb/tb_mo_responder.sv
// tb_mo_responder: random and directed stimulus checked every cycle against a behavioural model of the responder
module tb_mo_responder;
  localparam int DW = 10, YW = 20;
  logic clk = 0, reset = 1, ld_en = 0, start = 0, fin = 0;
  logic [2:0] ld_sel = 0, opcode = 7;
  logic [DW-1:0] ld_i = 0, ld_j = 0, ld_data = 0, i = 0, j = 0, rd_i = 0, rd_j = 0;
  logic [YW-1:0] out_data = 0;
  logic [DW-1:0] in_data, y_cnt;
  logic [YW-1:0] y_rdata;
  logic busy, done, err_proto;
  mo_responder dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel), .ld_i(ld_i), .ld_j(ld_j),
    .ld_data(ld_data), .start(start), .opcode(opcode), .i(i), .j(j), .out_data(out_data),
    .fin(fin), .in_data(in_data), .rd_i(rd_i), .rd_j(rd_j), .y_rdata(y_rdata), .busy(busy),
    .done(done), .y_cnt(y_cnt), .err_proto(err_proto)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // model: state 0 idle, 1 run, 2 done; allowed successor opcodes per previous opcode as bit masks
  int m_state = 0, m_n = 0, m_r = 0, m_prev = 7, m_cnt = 0, m_err = 0;
  int ma [3][8][8];
  int my [8][8];
  bit yv [8][8];
  bit live = 0;
  int nxt_mask [8] = '{2, 4, 8, 20, 32, 4, 0, 1};
  function automatic int exp_in();
    if (m_state != 1) return 0;
    if (opcode == 0) return m_n;
    if (opcode == 1) return m_r;
    if (opcode >= 2 && opcode <= 4 && i < m_n && j < m_n && i < 8 && j < 8) return ma[int'(opcode) - 2][i][j];
    return 0;
  endfunction
  always @(posedge clk) begin
    bit lg, inr;
    lg = opcode == 7 || nxt_mask[m_prev][opcode];
    inr = i < m_n && j < m_n && i < 8 && j < 8;
    if (reset) begin
      m_state = 0; m_n = 0; m_r = 0; m_prev = 7; m_cnt = 0; m_err = 0;
    end else if (m_state == 1) begin
      if (opcode == 5 && inr) begin
        my[i][j] = int'(out_data);
        yv[i][j] = 1;
        m_cnt = (m_cnt + 1) % 1024;
      end
      if (!lg) m_err = 1;
      m_prev = opcode;
      if (fin) m_state = 2;
    end else begin
      if (m_state == 0 && ld_en) begin
        if (ld_sel == 0) m_n = ld_data;
        else if (ld_sel == 1) m_r = ld_data;
        else if (ld_sel <= 4 && ld_i < 8 && ld_j < 8) ma[int'(ld_sel) - 2][ld_i][ld_j] = ld_data;
      end
      if (start) begin
        m_state = 1; m_prev = 7; m_cnt = 0; m_err = 0;
      end
    end
    live = 1;
  end
  always @(negedge clk) if (live) begin
    chk("busy", busy, m_state == 1);
    chk("done", done, m_state == 2);
    chk("y_cnt", y_cnt, m_cnt);
    chk("err_proto", err_proto, m_err);
    chk("in_data", in_data, exp_in());
    if (rd_i >= 8 || rd_j >= 8) chk("y_rdata_oor", y_rdata, 0);
    else if (yv[rd_i][rd_j]) chk("y_rdata", y_rdata, my[rd_i][rd_j]);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int sel, input int li, input int lj, input int d);
    ld_en = 1; ld_sel = 3'(sel); ld_i = 10'(li); ld_j = 10'(lj); ld_data = 10'(d);
    step();
    ld_en = 0;
  endtask
  function automatic logic [2:0] nxt(input logic [2:0] p);
    case (p)
      3'd7: return 3'd0;
      3'd0: return 3'd1;
      3'd1: return 3'd2;
      3'd2: return 3'd3;
      3'd3: return ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd4;
      3'd4: return 3'd5;
      3'd5: return 3'd2;
      default: return 3'd7;
    endcase
  endfunction
  initial begin
    step(); step();
    reset = 0;
    chk("reset_busy", busy, 0);
    chk("reset_ycnt", y_cnt, 0);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) load(2 + k, r, c, $urandom_range(0, 1023));
    load(0, 0, 0, 2); load(1, 0, 0, 1);
    load(2, 0, 0, 1); load(2, 0, 1, 2); load(2, 1, 0, 3); load(2, 1, 1, 4);
    start = 1; step(); start = 0;
    opcode = 0; #1 chk("get_n", in_data, 2); step();
    opcode = 1; #1 chk("get_r", in_data, 1); step();
    opcode = 2; i = 1; j = 0; #1 chk("read_a", in_data, 3); step();
    opcode = 3; i = 2; j = 0; #1 chk("read_x_oor", in_data, 0); step();
    chk("err_after_oor", err_proto, 0);
    opcode = 4; i = 0; j = 0; step();
    opcode = 5; i = 1; j = 1; out_data = 12345; step();
    rd_i = 1; rd_j = 1; #1 chk("y_written", y_rdata, 12345); chk("y_cnt_1", y_cnt, 1);
    opcode = 2; step(); opcode = 3; step(); opcode = 4; step();
    opcode = 5; i = 2; j = 0; step();
    chk("y_cnt_oor", y_cnt, 1);
    opcode = 2; step(); opcode = 3; step(); opcode = 4; step();
    opcode = 5; i = 0; j = 1; out_data = 777; fin = 1; step(); fin = 0;
    chk("done_after_fin", done, 1); chk("y_cnt_fin", y_cnt, 2);
    rd_i = 0; rd_j = 1; #1 chk("y_fin_write", y_rdata, 777);
    opcode = 5; i = 0; j = 0; out_data = 99; ld_en = 1; ld_sel = 0; ld_data = 5; step(); ld_en = 0;
    chk("y_cnt_done", y_cnt, 2);
    start = 1; opcode = 7; step(); start = 0;
    chk("restart_ycnt", y_cnt, 0); chk("restart_busy", busy, 1);
    opcode = 0; #1 chk("n_kept", in_data, 2); step();
    opcode = 7; step(); opcode = 0; step();
    chk("err_0", err_proto, 0);
    opcode = 2; step();
    chk("err_1", err_proto, 1);
    opcode = 7; repeat (3) step();
    chk("err_sticky", err_proto, 1);
    opcode = 5; i = 0; j = 0; out_data = 4242; reset = 1; step(); reset = 0; opcode = 7;
    chk("rst_busy", busy, 0); chk("rst_ycnt", y_cnt, 0); chk("rst_err", err_proto, 0);
    rd_i = 1; rd_j = 1; #1 chk("y_kept", y_rdata, 12345);
    start = 1; step(); start = 0;
    opcode = 0; #1 chk("n_reset", in_data, 0); step();
    reset = 1; step(); reset = 0;
    load(0, 0, 0, 2);
    start = 1; opcode = 7; step(); start = 0;
    opcode = 0; step(); opcode = 1; step();
    opcode = 2; i = 1; j = 0; #1 chk("a_kept", in_data, 3); step();
    opcode = 7; fin = 1; step(); fin = 0;
    for (int e = 0; e < 40; e++) begin
      int len;
      logic [2:0] p;
      bit r;
      if (e == 0 || $urandom_range(0, 2) == 0) begin
        reset = 1; step(); reset = 0;
        load(0, 0, 0, $urandom_range(0, 8));
        load(1, 0, 0, $urandom_range(0, 1023));
        repeat (6) load($urandom_range(2, 7), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 1023));
      end
      start = 1; opcode = 7; step(); start = 0;
      len = $urandom_range(5, 40);
      p = 3'd7;
      for (int c = 0; c < len; c++) begin
        p = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : nxt(p);
        opcode = p; i = 10'($urandom_range(0, 9)); j = 10'($urandom_range(0, 9));
        out_data = 20'($urandom); rd_i = 10'($urandom_range(0, 9)); rd_j = 10'($urandom_range(0, 9));
        ld_en = $urandom_range(0, 4) == 0; ld_sel = 3'($urandom_range(0, 7)); ld_data = 10'($urandom);
        start = $urandom_range(0, 9) == 0; fin = c == len - 1;
        reset = $urandom_range(0, 40) == 0;
        r = reset;
        step();
        reset = 0; start = 0; ld_en = 0; fin = 0;
        if (r) break;
      end
      repeat (2) begin
        opcode = 3'($urandom_range(0, 7)); i = 10'($urandom_range(0, 9)); j = 10'($urandom_range(0, 9));
        rd_i = 10'($urandom_range(0, 9)); rd_j = 10'($urandom_range(0, 9));
        step();
      end
    end
    reset = 1; step(); reset = 0;
    load(0, 0, 0, 8);
    start = 1; opcode = 7; step(); start = 0;
    opcode = 0; step(); opcode = 1; step();
    for (int k = 0; k < 1030; k++) begin
      opcode = 2; step(); opcode = 3; step(); opcode = 4; step();
      opcode = 5; i = 10'($urandom_range(0, 7)); j = 10'($urandom_range(0, 7)); out_data = 20'($urandom);
      rd_i = i; rd_j = j; step();
    end
    chk("y_cnt_wrap", y_cnt, 6);
    opcode = 7; fin = 1; step(); fin = 0;
    chk("wrap_done", done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
